// File: rtl/pe_cell_pkg.sv
// Shared definitions for the PE cell: FSM states, command mode codes and APB register map.
package pe_cell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WLOAD = 2'd1,
        ST_CALC  = 2'd2,
        ST_OUT   = 2'd3
    } pe_state_e;

    localparam logic [1:0] MODE_WLOAD = 2'b00;
    localparam logic [1:0] MODE_CALC  = 2'b01;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_DONE_CNT = 8'h08;

endpackage

// File: rtl/pe_mac_row.sv
// One weight row dot product: y = sum_c signed x[c] * w[c], combinational.
// Defining PE_ACC_SAT_EN saturates y to signed WID_ACC limits; otherwise y wraps.
module pe_mac_row #(
    parameter int WID_X   = 8,
    parameter int WID_Y   = 8,
    parameter int COL     = 4,
    parameter int WID_BUS = 32,
    parameter int WID_ACC = 32
) (
    input  logic [WID_BUS-1:0]        x_i,
    input  logic [WID_BUS-1:0]        w_i,
    output logic signed [WID_ACC-1:0] y_o
);
    localparam int SW = WID_X + WID_Y + $clog2(COL) + 1;
    localparam int FW = (SW > WID_ACC) ? SW : WID_ACC;

    logic signed [SW-1:0] sum;
    logic signed [FW-1:0] sum_f;

    // Operands are widened before multiplying so the product is never truncated.
    always_comb begin
        sum = '0;
        for (int c = 0; c < COL; c++) begin
            sum = sum + (SW'($signed(x_i[c*WID_X +: WID_X])) * SW'($signed(w_i[c*WID_Y +: WID_Y])));
        end
    end

    assign sum_f = FW'(sum);

`ifdef PE_ACC_SAT_EN
    localparam logic signed [FW-1:0] ACC_MAX = FW'({1'b0, {(WID_ACC-1){1'b1}}});
    localparam logic signed [FW-1:0] ACC_MIN = ~ACC_MAX;

    always_comb begin
        if (sum_f > ACC_MAX) begin
            y_o = ACC_MAX[WID_ACC-1:0];
        end else if (sum_f < ACC_MIN) begin
            y_o = ACC_MIN[WID_ACC-1:0];
        end else begin
            y_o = sum_f[WID_ACC-1:0];
        end
    end
`else
    assign y_o = sum_f[WID_ACC-1:0];
`endif

endmodule

// File: rtl/pe_cell_top.sv
// Processing-element cell: APB config, weight load stream, ROW-wide dot-product compute and result stream.
// Optional macro PE_ACC_SAT_EN (in pe_mac_row) selects saturating accumulation.
//
// state | meaning
// IDLE  | waiting for an accepted command
// WLOAD | each input beat written to the current weight row
// CALC  | waiting for an input vector
// OUT   | streaming y[0..ROW-1] to the sink
module pe_cell_top
    import pe_cell_pkg::*;
#(
    parameter int WID_X   = 8,
    parameter int WID_Y   = 8,
    parameter int ROW     = 4,
    parameter int COL     = 4,
    parameter int WID_BUS = 32,
    parameter int WID_ACC = 32,
    parameter int DLY     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         pe_id,
    input  logic               psel,
    input  logic [7:0]         paddr,
    input  logic               pwrite,
    input  logic [WID_BUS-1:0] pwdata,
    input  logic               penable,
    output logic [WID_BUS-1:0] prdata,
    output logic               pready,
    input  logic [WID_BUS-1:0] wdata,
    input  logic               wdata_valid,
    output logic               wdata_busy,
    input  logic               wdata_last,
    output logic [WID_BUS-1:0] rdata,
    output logic               rdata_valid,
    input  logic               rdata_busy,
    output logic               rdata_last,
    input  logic               cs_n,
    input  logic               cvalid,
    output logic               pe_busy,
    input  logic [1:0]         work_mode,
    input  logic [3:0]         waddr
);
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

    // DLY only shaped update timing in older behavioural models; it has no hardware meaning.
    if (DLY < 0) begin : g_dly_unused
    end

    pe_state_e             state_q;
    logic [RW-1:0]         row_q;
    logic [RW-1:0]         row_nxt;
    logic [RW-1:0]         start_row;
    logic                  last_q;
    logic                  pe_busy_q;
    logic                  err_q;
    logic [WID_BUS-1:0]    done_cnt_q;
    logic [WID_BUS-1:0]    ctrl_q;
    logic [WID_BUS-1:0]    prdata_q;
    logic [WID_BUS-1:0]    rd_d;
    logic [WID_BUS-1:0]    rdata_q;
    logic                  rdata_valid_q;
    logic                  rdata_last_q;
    logic [WID_BUS-1:0]    w_q [ROW];
    logic signed [WID_ACC-1:0] y_q [ROW];
    logic signed [WID_ACC-1:0] y_w [ROW];
    logic                  cmd_go;
    logic                  in_xfer;

    for (genvar r = 0; r < ROW; r++) begin : g_row
        pe_mac_row #(
            .WID_X   (WID_X),
            .WID_Y   (WID_Y),
            .COL     (COL),
            .WID_BUS (WID_BUS),
            .WID_ACC (WID_ACC)
        ) u_mac (
            .x_i (wdata),
            .w_i (w_q[r]),
            .y_o (y_w[r])
        );
    end

    assign pready      = 1'b1;
    assign prdata      = prdata_q;
    assign pe_busy     = pe_busy_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;
    assign wdata_busy  = !(state_q == ST_WLOAD || state_q == ST_CALC);

    assign cmd_go    = !cs_n && cvalid && ctrl_q[0] && (state_q == ST_IDLE);
    assign in_xfer   = wdata_valid && !wdata_busy;
    assign row_nxt   = (row_q == RW'(ROW - 1)) ? '0 : row_q + RW'(1);
    assign start_row = RW'(32'(waddr) % ROW);

    always_comb begin
        rd_d = '0;
        case (paddr)
            REG_CTRL:     rd_d = ctrl_q;
            REG_STATUS: begin
                rd_d[0]    = pe_busy_q;
                rd_d[1]    = err_q;
                rd_d[11:8] = pe_id;
            end
            REG_DONE_CNT: rd_d = done_cnt_q;
            default:      rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            prdata_q <= '0;
        end else begin
            if (psel && penable && pwrite && (paddr == REG_CTRL)) begin
                ctrl_q <= pwdata;
            end
            if (psel && !penable && !pwrite) begin
                prdata_q <= rd_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            last_q        <= 1'b0;
            pe_busy_q     <= 1'b0;
            err_q         <= 1'b0;
            done_cnt_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            for (int r = 0; r < ROW; r++) begin
                w_q[r] <= '0;
                y_q[r] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_go) begin
                        if (work_mode == MODE_WLOAD) begin
                            state_q   <= ST_WLOAD;
                            row_q     <= start_row;
                            pe_busy_q <= 1'b1;
                            err_q     <= 1'b0;
                        end else if (work_mode == MODE_CALC) begin
                            state_q   <= ST_CALC;
                            pe_busy_q <= 1'b1;
                            err_q     <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WLOAD: begin
                    if (in_xfer) begin
                        w_q[row_q] <= wdata;
                        row_q      <= row_nxt;
                        if (wdata_last) begin
                            state_q    <= ST_IDLE;
                            pe_busy_q  <= 1'b0;
                            done_cnt_q <= done_cnt_q + WID_BUS'(1);
                        end
                    end
                end
                ST_CALC: begin
                    if (in_xfer) begin
                        for (int r = 0; r < ROW; r++) begin
                            y_q[r] <= y_w[r];
                        end
                        last_q        <= wdata_last;
                        row_q         <= '0;
                        rdata_q       <= WID_BUS'(y_w[0]);
                        rdata_valid_q <= 1'b1;
                        rdata_last_q  <= wdata_last && (ROW == 1);
                        state_q       <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // row_q doubles as the output index; rdata_valid is always high here.
                    if (!rdata_busy) begin
                        if (row_q == RW'(ROW - 1)) begin
                            rdata_valid_q <= 1'b0;
                            rdata_last_q  <= 1'b0;
                            if (last_q) begin
                                state_q    <= ST_IDLE;
                                pe_busy_q  <= 1'b0;
                                done_cnt_q <= done_cnt_q + WID_BUS'(1);
                            end else begin
                                state_q <= ST_CALC;
                            end
                        end else begin
                            row_q        <= row_nxt;
                            rdata_q      <= WID_BUS'(y_q[row_nxt]);
                            rdata_last_q <= last_q && (row_nxt == RW'(ROW - 1));
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_cell_top.sv
// Directed, table-driven bench for pe_cell_top with hand-computed expectations.
module tb_pe_cell_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  pe_id = 4'd5;
    logic        psel = 1'b0;
    logic [7:0]  paddr = 8'h00;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        penable = 1'b0;
    logic [31:0] prdata;
    logic        pready;
    logic [31:0] wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_busy;
    logic        wdata_last = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_busy = 1'b0;
    logic        rdata_last;
    logic        cs_n = 1'b1;
    logic        cvalid = 1'b0;
    logic        pe_busy;
    logic [1:0]  work_mode = 2'b00;
    logic [3:0]  waddr = 4'd0;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [31:0]       x;
        logic              last;
        logic [3:0][31:0]  y;
    } vec_t;

    vec_t        vecs [3];
    logic [31:0] wrows [4];

    pe_cell_top dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pe_id       (pe_id),
        .psel        (psel),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .penable     (penable),
        .prdata      (prdata),
        .pready      (pready),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_busy  (wdata_busy),
        .wdata_last  (wdata_last),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_busy  (rdata_busy),
        .rdata_last  (rdata_last),
        .cs_n        (cs_n),
        .cvalid      (cvalid),
        .pe_busy     (pe_busy),
        .work_mode   (work_mode),
        .waddr       (waddr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [31:0] x, input logic last,
                                input logic [31:0] y0, input logic [31:0] y1,
                                input logic [31:0] y2, input logic [31:0] y3);
        vec_t v;
        v.x    = x;
        v.last = last;
        v.y[0] = y0;
        v.y[1] = y1;
        v.y[2] = y2;
        v.y[3] = y3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_check(input logic [7:0] a, input logic [31:0] exp, input string name);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        tick();
        penable = 1'b1;
        chk(name, prdata, exp);
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic start_cmd(input logic [1:0] mode, input logic [3:0] wa);
        cs_n = 1'b0; cvalid = 1'b1; work_mode = mode; waddr = wa;
        tick();
        cs_n = 1'b1; cvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int n = 0;
        wdata = d; wdata_last = last; wdata_valid = 1'b1;
        while (wdata_busy && n < 50) begin
            tick();
            n++;
        end
        chk("wdata_accept", {31'b0, wdata_busy}, 32'd0);
        tick();
        wdata_valid = 1'b0; wdata_last = 1'b0;
    endtask

    task automatic collect(input logic [3:0][31:0] y, input logic last, input string tag);
        for (int r = 0; r < 4; r++) begin
            int n = 0;
            while (!rdata_valid && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("%s_valid%0d", tag, r), {31'b0, rdata_valid}, 32'd1);
            chk($sformatf("%s_y%0d", tag, r), rdata, y[r]);
            chk($sformatf("%s_last%0d", tag, r), {31'b0, rdata_last}, {31'b0, last && (r == 3)});
            tick();
        end
    endtask

    initial begin
        wrows[0] = 32'h0403_0201;
        wrows[1] = 32'hFFFF_FFFF;
        wrows[2] = 32'h8000_007F;
        wrows[3] = 32'h0200_0000;
        vecs[0] = mk(32'h0101_0101, 1'b0, 32'd10,  -32'sd4,   -32'sd1,    32'd2);
        vecs[1] = mk(32'h04FD_02FF, 1'b0, 32'd10,  -32'sd2,   -32'sd639,  32'd8);
        vecs[2] = mk(32'h8000_807F, 1'b1, -32'sd641, 32'd129, 32'd32513,  -32'sd256);

        #12;
        chk("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        chk("rst_rdata_last",  {31'b0, rdata_last},  32'd0);
        chk("rst_rdata",       rdata,                32'd0);
        chk("rst_pe_busy",     {31'b0, pe_busy},     32'd0);
        chk("rst_prdata",      prdata,               32'd0);
        chk("rst_pready",      {31'b0, pready},      32'd1);
        rst_n = 1'b1;
        tick();

        start_cmd(2'b01, 4'd0);
        chk("cmd_ignored_disabled", {31'b0, pe_busy}, 32'd0);

        apb_write(8'h00, 32'h1);
        apb_check(8'h00, 32'h1,   "ctrl_read");
        apb_check(8'h04, 32'h500, "status_idle");
        apb_check(8'h20, 32'h0,   "unmapped_read");
        apb_write(8'h04, 32'hFFFF_FFFF);
        apb_check(8'h04, 32'h500, "status_ro");
        apb_check(8'h08, 32'h0,   "done_cnt_init");

        start_cmd(2'b00, 4'd0);
        chk("busy_wload", {31'b0, pe_busy}, 32'd1);
        for (int r = 0; r < 4; r++) send_beat(32'h0101_0101, r == 3);
        chk("busy_drop_wload", {31'b0, pe_busy}, 32'd0);
        start_cmd(2'b01, 4'd0);
        chk("busy_calc", {31'b0, pe_busy}, 32'd1);
        send_beat(32'h0403_0201, 1'b1);
        chk("wdata_busy_out", {31'b0, wdata_busy}, 32'd1);
        collect(mk(32'h0, 1'b1, 32'd10, 32'd10, 32'd10, 32'd10).y, 1'b1, "ones");
        chk("busy_drop_calc", {31'b0, pe_busy}, 32'd0);
        apb_check(8'h08, 32'd2, "done_cnt_2");

        start_cmd(2'b00, 4'd0);
        for (int r = 0; r < 4; r++) send_beat(wrows[r], r == 3);
        start_cmd(2'b01, 4'd0);
        for (int i = 0; i < 3; i++) begin
            send_beat(vecs[i].x, vecs[i].last);
            collect(vecs[i].y, vecs[i].last, $sformatf("vec%0d", i));
        end
        chk("busy_drop_table", {31'b0, pe_busy}, 32'd0);
        apb_check(8'h08, 32'd4, "done_cnt_4");

        start_cmd(2'b00, 4'd3);
        send_beat(32'h0000_0003, 1'b0);
        send_beat(32'h0000_00FF, 1'b1);
        start_cmd(2'b01, 4'd0);
        send_beat(32'h0000_0005, 1'b1);
        chk("stall_y0_first", rdata, 32'hFFFF_FFFB);
        rdata_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall_rdata%0d", k), rdata, 32'hFFFF_FFFB);
            chk($sformatf("stall_valid%0d", k), {31'b0, rdata_valid}, 32'd1);
        end
        rdata_busy = 1'b0;
        collect(mk(32'h0, 1'b1, -32'sd5, -32'sd5, 32'd635, 32'd15).y, 1'b1, "wrap");
        apb_check(8'h08, 32'd6, "done_cnt_6");

        start_cmd(2'b10, 4'd0);
        chk("reserved_pe_busy",    {31'b0, pe_busy},    32'd0);
        chk("reserved_wdata_busy", {31'b0, wdata_busy}, 32'd1);
        apb_check(8'h04, 32'h502, "status_err");
        start_cmd(2'b01, 4'd0);
        apb_check(8'h04, 32'h501, "status_err_cleared");
        send_beat(32'h0101_0101, 1'b1);
        chk("pre_reset_valid", {31'b0, rdata_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        chk("reset_rdata_last",  {31'b0, rdata_last},  32'd0);
        chk("reset_rdata",       rdata,                32'd0);
        chk("reset_pe_busy",     {31'b0, pe_busy},     32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset_wdata_busy", {31'b0, wdata_busy},  32'd1);
        chk("idle_after_reset_valid",      {31'b0, rdata_valid}, 32'd0);
        apb_check(8'h08, 32'd0, "done_cnt_after_reset");
        apb_check(8'h00, 32'd0, "ctrl_after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_cell_top.md
PE_CELL_TOP -- requirements
Module: pe_cell_top

Interface
REQ-001 SHALL have parameter WID_X, default 8: input-vector element width.
REQ-002 SHALL have parameter WID_Y, default 8: weight element width.
REQ-003 SHALL have parameter ROW, default 4: weight rows, i.e. results per vector.
REQ-004 SHALL have parameter COL, default 4: elements per row/vector.
REQ-005 SHALL have parameter WID_BUS, default 32: stream/APB data width; required WID_BUS == COL*WID_X == COL*WID_Y.
REQ-006 SHALL have parameter WID_ACC, default 32: accumulator width, <= WID_BUS.
REQ-007 SHALL have parameter DLY, default 1: simulation-only register update delay; no functional effect.
REQ-008 SHALL have port clk, in, 1: the single clock; all logic on rising edge.
REQ-009 SHALL have port rst_n, in, 1: reset, asynchronous and active-low.
REQ-010 SHALL have port pe_id, in, 4: static cell identifier, readable via APB.
REQ-011 SHALL have port psel, in, 1: APB select.
REQ-012 SHALL have port paddr, in, 8: APB byte address.
REQ-013 SHALL have port pwrite, in, 1: APB write.
REQ-014 SHALL have port pwdata, in, WID_BUS: APB write data.
REQ-015 SHALL have port penable, in, 1: APB access phase.
REQ-016 SHALL have port prdata, out, WID_BUS: APB read data.
REQ-017 SHALL have port pready, out, 1: APB ready.
REQ-018 SHALL have port wdata, in, WID_BUS: input stream beat; element c at bits [c*W+W-1:c*W].
REQ-019 SHALL have port wdata_valid, in, 1: input beat valid.
REQ-020 SHALL have port wdata_busy, out, 1: cell cannot accept input.
REQ-021 SHALL have port wdata_last, in, 1: final input beat of the command.
REQ-022 SHALL have port rdata, out, WID_BUS: result, sign-extended.
REQ-023 SHALL have port rdata_valid, out, 1: result valid.
REQ-024 SHALL have port rdata_busy, in, 1: sink stall.
REQ-025 SHALL have port rdata_last, out, 1: final result of the command.
REQ-026 SHALL have port cs_n, in, 1: active-low command select.
REQ-027 SHALL have port cvalid, in, 1: command valid.
REQ-028 SHALL have port pe_busy, out, 1: command in progress.
REQ-029 SHALL have port work_mode, in, 2: 00 weight load, 01 compute, 10/11 reserved.
REQ-030 SHALL have port waddr, in, 4: start weight row (mod ROW).

Function
REQ-031 SHALL use zero-wait APB: pready=1; write on psel&penable&pwrite; prdata registered; regs 0x00 CTRL RW (bit0 enable), 0x04 STATUS RO (bit0 pe_busy, bit1 err, [11:8] pe_id), 0x08 DONE_CNT RO (completed commands, wraps); unmapped reads 0, RO writes ignored.
REQ-032 SHALL accept a command only when cs_n=0, cvalid=1, CTRL.enable=1, state IDLE; pe_busy rises the next cycle.
REQ-033 SHALL run FSM IDLE->WLOAD (mode 00) or IDLE->CALC (mode 01); reserved mode sets err, stays IDLE; err cleared by next valid command.
REQ-034 SHALL transfer input when wdata_valid&!wdata_busy and output when rdata_valid&!rdata_busy; wdata_busy=1 outside WLOAD/CALC.
REQ-035 SHALL in WLOAD write each beat to weight row r, starting at waddr, incrementing with wrap ROW-1->0; wdata_last -> IDLE.
REQ-036 SHALL in CALC compute y[r]=sum over c of signed x[c]*w[r][c] for all rows in one cycle after acceptance, then enter OUT with wdata_busy=1.
REQ-037 SHALL in OUT present y[0..ROW-1] in order, rdata/rdata_valid held stable while rdata_busy=1; after y[ROW-1] returns to CALC, or to IDLE if that vector had wdata_last, with rdata_last on that beat only.
REQ-038 SHALL drop pe_busy and increment DONE_CNT the cycle after the final transfer of a command.

Reset
REQ-039 SHALL on rst_n=0 immediately clear all outputs except pready, FSM to IDLE, registers, counters and weights to 0; reset mid-command aborts without partial output.

Configuration
REQ-040 SHALL with PE_ACC_SAT_EN defined saturate y to signed WID_ACC limits; without it wrap modulo 2^WID_ACC.

Structure
REQ-041 SHALL place FSM state enum, mode codes and register offsets in package pe_cell_pkg, with one sub-module pe_mac_row computing one row dot product, instantiated ROW times.

Verification
REQ-042 SHALL check APB: write 0x1 to 0x00, pe_id=5 -> read 0x00=1, 0x04=0x500, read 0x20=0.
REQ-043 SHALL check load/compute: weights all 1 (rows 0..3), compute x=[1,2,3,4] with last -> rdata 10,10,10,10, rdata_last on 4th, DONE_CNT=2.
REQ-044 SHALL check signed: w row0=[-1,0,0,0], x=[5,...] -> y0=0xFFFFFFFB.
REQ-045 SHALL check wrap and stall: load 2 rows at waddr=3 -> rows 3,0 written; rdata_busy held 3 cycles -> rdata stable, no beat lost.
REQ-046 SHALL check mode 10 -> STATUS.err=1, pe_busy=0; rst_n low mid-OUT -> rdata_valid=0 at once, then IDLE.
